// File: rtl/wb_ram_dual_port_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone RAM arbiter.
// Carries no logic and no latency of its own.
package wb_ram_dual_port_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/wb_ram_dual_port_arbiter_if.sv
// Wishbone B3 classic port, one instance per master.
// The slave acks one cycle after grant and has no wait-state backpressure beyond that.
interface wb_ram_dual_port_arbiter_if #(
  parameter int ADDR_WIDTH = 11
);

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [ADDR_WIDTH+1:0] adr;
  logic [3:0]            sel;
  logic [31:0]           dat_w;
  logic [31:0]           dat_r;
  logic                  ack;

  modport master (
    output cyc, stb, we, adr, sel, dat_w,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_w,
    output dat_r, ack
  );

endinterface

// File: rtl/wb_ram_dual_port_arbiter_rr_arbiter_2.sv
// Combinational two-way round-robin grant; zero latency.
// On contention the grant goes to the requester that did not win last time.
module wb_ram_dual_port_arbiter_rr_arbiter_2
  import wb_ram_dual_port_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_gnt_vld,
  output logic       o_gnt
);

  always_comb begin
    o_gnt_vld = |i_req;
    case (i_req)
      2'b10:   o_gnt = M1;
      2'b11:   o_gnt = ~i_last_grant;
      default: o_gnt = M0;
    endcase
  end

endmodule

// File: rtl/wb_ram_dual_port_arbiter.sv
// Shares one byte-lane RAM bank between two Wishbone classic masters, round-robin.
// Ack follows grant by one cycle; one access per two cycles; losers simply wait with stb held.
module wb_ram_dual_port_arbiter
  import wb_ram_dual_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  wb_ram_dual_port_arbiter_if.slave m0,
  wb_ram_dual_port_arbiter_if.slave m1,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [3:0]            ram_we_o,
  output logic [31:0]           ram_data_o,
  input  logic [31:0]           ram_data_i
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_grant;
  logic       r_last_grant;
  logic [1:0] w_req;
  logic       w_gnt_vld;
  logic       w_gnt;
  logic       w_issue;
  logic       w_bus_sel;
  logic [3:0] w_unused_adr_bits;

  assign w_req             = {m1.cyc & m1.stb, m0.cyc & m0.stb};
  assign w_issue           = (r_state == ST_IDLE) & w_gnt_vld;
  assign w_unused_adr_bits = {m1.adr[1:0], m0.adr[1:0]};

  wb_ram_dual_port_arbiter_rr_arbiter_2 u_rr (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_gnt_vld    (w_gnt_vld),
    .o_gnt        (w_gnt)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= ST_IDLE;
      r_grant      <= M0;
      r_last_grant <= M1;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_grant      <= w_gnt;
        r_last_grant <= w_gnt;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_gnt_vld) w_state_nxt = ST_ACK;
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outside an issue cycle the address bus idles on the last winner's address.
  assign w_bus_sel = w_issue ? w_gnt : r_last_grant;

  always_comb begin
    ram_addr_o = m0.adr[ADDR_WIDTH+1:2];
    ram_data_o = m0.dat_w;
    ram_we_o   = 4'b0000;
    if (w_bus_sel == M1) begin
      ram_addr_o = m1.adr[ADDR_WIDTH+1:2];
      ram_data_o = m1.dat_w;
    end
    if (w_issue) begin
      if (w_gnt == M1) ram_we_o = m1.we ? m1.sel : 4'b0000;
      else             ram_we_o = m0.we ? m0.sel : 4'b0000;
    end
  end

  // A master that dropped its request during the ack cycle has aborted and gets no ack.
  assign m0.ack   = (r_state == ST_ACK) & (r_grant == M0) & w_req[0];
  assign m1.ack   = (r_state == ST_ACK) & (r_grant == M1) & w_req[1];
  assign m0.dat_r = ram_data_i;
  assign m1.dat_r = ram_data_i;

endmodule
